// File: rtl/lane_mutate_ctrl_if.sv
// Gene source and destination handshakes of the lane mutation controller.
interface lane_mutate_ctrl_if #(
  parameter int unsigned GENE_SZ = 64
);
  logic               src_valid;
  logic [GENE_SZ-1:0] src_gene;
  logic               src_ready;
  logic               dst_valid;
  logic [GENE_SZ-1:0] dst_gene;
  logic               dst_ready;

  // Environment side: produces source genes, consumes destination genes.
  modport master (
    output src_valid, src_gene, dst_ready,
    input  src_ready, dst_valid, dst_gene
  );

  // Controller side.
  modport slave (
    input  src_valid, src_gene, dst_ready,
    output src_ready, dst_valid, dst_gene
  );
endinterface

// File: rtl/lane_mutate_ctrl.sv
// Streams one genome pass through a mutation lane: credit-limited issue,
// lane return buffering in a fall-through FIFO, and pass completion tracking.
module lane_mutate_ctrl #(
  parameter int unsigned GENE_SZ    = 64,
  parameter int unsigned ATTR_SZ    = 8,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   genome_len,
  input  logic [ATTR_SZ-1:0] node_del_prob_cfg,
  input  logic [ATTR_SZ-1:0] conn_del_prob_cfg,
  lane_mutate_ctrl_if.slave  bus,
  output logic [1:0]         lane_state,
  output logic [GENE_SZ-1:0] lane_gene_in,
  output logic               lane_in_valid,
  output logic [ATTR_SZ-1:0] node_del_prob,
  output logic [ATTR_SZ-1:0] conn_del_prob,
  output logic [ATTR_SZ-1:0] random,
  input  logic [GENE_SZ-1:0] lane_out,
  input  logic               lane_out_valid,
  input  logic [ATTR_SZ-1:0] lane_max,
  output logic               busy,
  output logic               done,
  output logic [ATTR_SZ-1:0] hidden_node_max,
  output logic               ovf_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   issued;
  logic [CNT_W-1:0]   received;
  logic [CW-1:0]      credit;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [GENE_SZ-1:0] mem [FIFO_DEPTH];
  logic [15:0]        lfsr;

  logic fifo_empty_c, fifo_full_c, issue_c, pop_c, push_c, push_ok_c;
  logic last_issue_c, drain_done_c;

  // Handshake qualification and FIFO status.
  always_comb begin
    fifo_empty_c  = (count == '0);
    fifo_full_c   = (count == CW'(FIFO_DEPTH));
    bus.src_ready = (state == S_STREAM) && (credit != '0) && (issued < len_q);
    issue_c       = bus.src_valid && bus.src_ready;
    bus.dst_valid = !fifo_empty_c;
    bus.dst_gene  = mem[rd_ptr];
    pop_c         = bus.dst_valid && bus.dst_ready;
    // Lane returns only count while a pass is actually streaming or draining.
    push_c        = lane_out_valid && ((state == S_STREAM) || (state == S_DRAIN));
    push_ok_c     = push_c && (!fifo_full_c || pop_c);
    last_issue_c  = issue_c && (issued == len_q - CNT_W'(1));
    drain_done_c  = (received == len_q) &&
                    (fifo_empty_c || ((count == CW'(1)) && pop_c && !push_ok_c));
  end

  // Lane state, busy and done decoded from the state register.
  always_comb begin
    lane_state = 2'b00;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_CONFIG: begin lane_state = 2'b01; busy = 1'b1; end
      S_STREAM: begin lane_state = 2'b10; busy = 1'b1; end
      S_DRAIN:  begin lane_state = 2'b11; busy = 1'b1; end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  assign random = lfsr[ATTR_SZ-1:0];

  // Pass FSM, counters, credit, lane issue register and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      len_q           <= '0;
      issued          <= '0;
      received        <= '0;
      credit          <= CW'(FIFO_DEPTH);
      node_del_prob   <= '0;
      conn_del_prob   <= '0;
      hidden_node_max <= '0;
      ovf_err         <= 1'b0;
      lane_gene_in    <= '0;
      lane_in_valid   <= 1'b0;
    end else begin
      lane_in_valid <= issue_c;
      if (issue_c) lane_gene_in <= bus.src_gene;
      if (issue_c) issued <= issued + CNT_W'(1);
      if (push_c) received <= received + CNT_W'(1);
      if (push_c && !push_ok_c) ovf_err <= 1'b1;
      case ({issue_c, pop_c})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: ;
      endcase
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q         <= genome_len;
            node_del_prob <= node_del_prob_cfg;
            conn_del_prob <= conn_del_prob_cfg;
            issued        <= '0;
            received      <= '0;
            state         <= S_CONFIG;
          end
        end
        S_CONFIG: state <= (len_q != '0) ? S_STREAM : S_DONE;
        S_STREAM: if (last_issue_c) state <= S_DRAIN;
        S_DRAIN: begin
          if (drain_done_c) begin
            state           <= S_DONE;
            hidden_node_max <= lane_max;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= lane_out;
  end

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

endmodule
